z80_bus_bridge: RTL and testbench

- Synchronous bridge between the tv80s Z80 bus pins and a single-port request/acknowledge memory back end.
- Sits directly upstream of the CPU's `di` and `wait_n` inputs, and replaces the ad-hoc negedge memory model.
- Decodes memory and I/O read/write cycles, issues one back-end request per bus cycle, and stretches the cycle with `wait_n`.
- Returns read data to the CPU on a registered `cpu_di`.

---
 rtl/z80_bus_pkg.sv | 40 ++++
 rtl/z80_cycle_decode.sv | 41 ++++
 rtl/z80_bus_bridge.sv | 155 +++++++++++++++
 tb/tb_z80_bus_bridge.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the tv80s bus bridge: FSM state and
// bus-cycle enums, reset values of the CPU-facing registers, and the helper
// that picks the post-ack wait count for a cycle type.
package z80_bus_pkg;

   // Bridge FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } bus_state_t;

   // Kind of CPU bus cycle that started a transfer.
   typedef enum logic {
      CYC_MEM = 1'b0,
      CYC_IO  = 1'b1
   } cycle_t;

   // High address byte placed in front of the 8-bit I/O port number.
   localparam logic [7:0]  DEF_IO_PAGE   = 8'h10;

   // Reset values of the CPU and back-end facing registers.
   localparam logic [7:0]  CPU_DI_RST    = 8'hFF;
   localparam logic [15:0] MEM_ADDR_RST  = 16'h0000;
   localparam logic [7:0]  MEM_WDATA_RST = 8'h00;

   // Width of the post-ack wait counter.
   localparam int unsigned WAIT_W = 4;

   // Wait count to load when a cycle is accepted.
   function automatic logic [WAIT_W-1:0] wait_load(
      input cycle_t            cyc,
      input logic [WAIT_W-1:0] mem_wait,
      input logic [WAIT_W-1:0] io_wait
   );
      return (cyc == CYC_IO) ? io_wait : mem_wait;
   endfunction

endpackage

// File: rtl/z80_cycle_decode.sv
// Purely combinational decode of the Z80 bus strobes. Reports whether a
// memory or I/O read/write cycle is being started, its direction, and
// whether the CPU has released both request strobes. Refresh cycles and
// interrupt-acknowledge cycles never produce a start.
module z80_cycle_decode (
   input  logic m1_n,
   input  logic mreq_n,
   input  logic iorq_n,
   input  logic rd_n,
   input  logic wr_n,
   input  logic rfsh_n,
   output logic start,
   output logic is_io,
   output logic is_wr,
   output logic released
);

   logic rd_or_wr;
   logic mem_cycle;
   logic io_cycle;

   assign rd_or_wr  = !rd_n || !wr_n;

   // Memory cycle: MREQ without refresh. RFSH low marks the refresh half of
   // an opcode fetch, which must not reach the back end.
   assign mem_cycle = !mreq_n && rfsh_n && rd_or_wr;

   // I/O cycle: IORQ without M1. IORQ together with M1 is an interrupt
   // acknowledge, which carries no port access.
   assign io_cycle  = !iorq_n && m1_n && rd_or_wr;

   assign start     = mem_cycle || io_cycle;

   // A well-formed CPU never raises both; memory wins if it ever happens.
   assign is_io     = io_cycle && !mem_cycle;
   assign is_wr     = !wr_n;

   // Both request strobes high: the current bus cycle is over.
   assign released  = mreq_n && iorq_n;

endmodule

// File: rtl/z80_bus_bridge.sv
// Bridge between the tv80s bus pins and a single-port req/ack memory back
// end. One back-end request is issued per CPU bus cycle; the CPU is held
// with cpu_wait_n until the ack plus a per-cycle-type number of extra wait
// cycles has elapsed. Read data is returned on the registered cpu_di.
module z80_bus_bridge
   import z80_bus_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 1,
   parameter logic [7:0]  IO_PAGE  = DEF_IO_PAGE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_m1_n,
   input  logic        cpu_mreq_n,
   input  logic        cpu_iorq_n,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   input  logic        cpu_rfsh_n,
   output logic [7:0]  cpu_di,
   output logic        cpu_wait_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        busy
);

   localparam logic [WAIT_W-1:0] MEM_WAIT_CNT = WAIT_W'(MEM_WAIT);
   localparam logic [WAIT_W-1:0] IO_WAIT_CNT  = WAIT_W'(IO_WAIT);

   bus_state_t        state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              aborted;

   logic              start;
   logic              is_io;
   logic              is_wr;
   logic              released;
   cycle_t            cyc;

   z80_cycle_decode u_decode (
      .m1_n     (cpu_m1_n),
      .mreq_n   (cpu_mreq_n),
      .iorq_n   (cpu_iorq_n),
      .rd_n     (cpu_rd_n),
      .wr_n     (cpu_wr_n),
      .rfsh_n   (cpu_rfsh_n),
      .start    (start),
      .is_io    (is_io),
      .is_wr    (is_wr),
      .released (released)
   );

   assign cyc  = is_io ? CYC_IO : CYC_MEM;

   // Busy is a pure function of the state register, so it carries no
   // combinational path from the CPU strobes.
   assign busy = (state != IDLE);

   // Bus-cycle FSM with the wait counter and all registered outputs.
   // NOTE: every register here uses <= so all of them update from the same
   // pre-edge values; a blocking = would let later lines see new state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         aborted    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= MEM_ADDR_RST;
         mem_wdata  <= MEM_WDATA_RST;
         cpu_di     <= CPU_DI_RST;
         cpu_wait_n <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= REQ;
                  mem_req    <= 1'b1;
                  cpu_wait_n <= 1'b0;
                  mem_addr   <= is_io ? {IO_PAGE, cpu_a[7:0]} : cpu_a;
                  mem_we     <= is_wr;
                  mem_wdata  <= cpu_do;
                  wait_cnt   <= wait_load(cyc, MEM_WAIT_CNT, IO_WAIT_CNT);
                  aborted    <= 1'b0;
               end
            end

            REQ: begin
               if (mem_ack) begin
                  // The back end has taken the transfer; never re-request.
                  mem_req <= 1'b0;
                  if (aborted || released) begin
                     // CPU has already left this cycle: drop the data.
                     state      <= IDLE;
                     cpu_wait_n <= 1'b1;
                     aborted    <= 1'b0;
                  end else begin
                     if (!mem_we) begin
                        cpu_di <= mem_rdata;
                     end
                     if (wait_cnt == '0) begin
                        state      <= HOLD;
                        cpu_wait_n <= 1'b1;
                     end else begin
                        state <= WAIT;
                     end
                  end
               end else if (released) begin
                  // Strobes gone before the ack: free the CPU now, but keep
                  // the request up so the back end sees a complete handshake.
                  aborted    <= 1'b1;
                  cpu_wait_n <= 1'b1;
               end
            end

            WAIT: begin
               if (released) begin
                  state      <= IDLE;
                  cpu_wait_n <= 1'b1;
               end else begin
                  // Saturating decrement: the counter never wraps below 0.
                  if (wait_cnt != '0) begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end
                  if (wait_cnt <= WAIT_W'(1)) begin
                     state      <= HOLD;
                     cpu_wait_n <= 1'b1;
                  end
               end
            end

            HOLD: begin
               // Wait for the strobes to drop so one bus cycle maps to
               // exactly one back-end request.
               if (released) begin
                  state <= IDLE;
               end
            end

            default: begin
               state      <= IDLE;
               mem_req    <= 1'b0;
               cpu_wait_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed bench for z80_bus_bridge. Two instances share the CPU-side
// stimulus and the back-end ack/data: dut_a uses the default waits
// (memory 0, I/O 1), dut_b uses a memory wait of 2.
module tb_z80_bus_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_do;
   logic        cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   logic [7:0]  a_cpu_di,    b_cpu_di;
   logic        a_cpu_wait_n, b_cpu_wait_n;
   logic        a_mem_req,   b_mem_req;
   logic        a_mem_we,    b_mem_we;
   logic [15:0] a_mem_addr,  b_mem_addr;
   logic [7:0]  a_mem_wdata, b_mem_wdata;
   logic        a_busy,      b_busy;

   int checks   = 0;
   int failures = 0;
   int a_pulses = 0;
   int pulses_before;
   logic a_req_q = 1'b0;

   always #5 clk = ~clk;

   z80_bus_bridge dut_a (
      .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
      .cpu_m1_n(cpu_m1_n), .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
      .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_rfsh_n(cpu_rfsh_n),
      .cpu_di(a_cpu_di), .cpu_wait_n(a_cpu_wait_n), .mem_req(a_mem_req),
      .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(a_busy)
   );

   z80_bus_bridge #(.MEM_WAIT(2)) dut_b (
      .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
      .cpu_m1_n(cpu_m1_n), .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
      .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_rfsh_n(cpu_rfsh_n),
      .cpu_di(b_cpu_di), .cpu_wait_n(b_cpu_wait_n), .mem_req(b_mem_req),
      .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(b_busy)
   );

   // Count rising edges of dut_a's request, sampled mid-cycle.
   always @(negedge clk) begin
      if (a_mem_req && !a_req_q) a_pulses++;
      a_req_q = a_mem_req;
   end

   // Wait counter is 4 bits wide; wider parameters are illegal.
   initial begin
      assert (dut_a.MEM_WAIT <= 15 && dut_a.IO_WAIT <= 15 &&
              dut_b.MEM_WAIT <= 15 && dut_b.IO_WAIT <= 15)
      else $fatal(1, "FAIL param_range: wait parameter exceeds 15");
   end

   // Run-time bound in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle; outputs are read 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes_idle();
      cpu_m1_n   = 1'b1;
      cpu_mreq_n = 1'b1;
      cpu_iorq_n = 1'b1;
      cpu_rd_n   = 1'b1;
      cpu_wr_n   = 1'b1;
      cpu_rfsh_n = 1'b1;
   endtask

   initial begin
      reset     = 1'b1;
      cpu_a     = 16'h0000;
      cpu_do    = 8'h00;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      strobes_idle();
      step();
      step();

      // Reset state.
      check("rst_req",    {15'd0, a_mem_req},    16'h0000);
      check("rst_we",     {15'd0, a_mem_we},     16'h0000);
      check("rst_wait_n", {15'd0, a_cpu_wait_n}, 16'h0001);
      check("rst_di",     {8'd0, a_cpu_di},      16'h00FF);
      check("rst_addr",   a_mem_addr,            16'h0000);
      check("rst_wdata",  {8'd0, a_mem_wdata},   16'h0000);
      check("rst_busy",   {15'd0, a_busy},       16'h0000);
      reset = 1'b0;
      step();

      // 1: memory read, MEM_WAIT=0, ack in the first request cycle.
      pulses_before = a_pulses;
      cpu_a = 16'h0000; mem_rdata = 8'hCB;
      cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
      step();
      check("t1_req",    {15'd0, a_mem_req},    16'h0001);
      check("t1_addr",   a_mem_addr,            16'h0000);
      check("t1_we",     {15'd0, a_mem_we},     16'h0000);
      check("t1_wait_lo",{15'd0, a_cpu_wait_n}, 16'h0000);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("t1_di",     {8'd0, a_cpu_di},      16'h00CB);
      check("t1_wait_hi",{15'd0, a_cpu_wait_n}, 16'h0001);
      check("t1_req_off",{15'd0, a_mem_req},    16'h0000);
      step();  // strobes still low: must stay in HOLD, no second request
      check("t1_hold_req",  {15'd0, a_mem_req}, 16'h0000);
      check("t1_hold_busy", {15'd0, a_busy},    16'h0001);
      strobes_idle();
      step();
      check("t1_idle",   {15'd0, a_busy},       16'h0000);
      check("t1_pulses", 16'(a_pulses - pulses_before), 16'd1);

      // Fresh reset so both instances start test 2 with cpu_di = FF.
      reset = 1'b1;
      step();
      reset = 1'b0;

      // 2: memory write on dut_b (MEM_WAIT=2), ack latency 0.
      cpu_a = 16'h2C39; cpu_do = 8'hC8;
      cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
      step();
      check("t2_req",    {15'd0, b_mem_req},    16'h0001);
      check("t2_we",     {15'd0, b_mem_we},     16'h0001);
      check("t2_wdata",  {8'd0, b_mem_wdata},   16'h00C8);
      check("t2_addr",   b_mem_addr,            16'h2C39);
      check("t2_wait_c1",{15'd0, b_cpu_wait_n}, 16'h0000);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("t2_req_off",{15'd0, b_mem_req},    16'h0000);
      check("t2_wait_c2",{15'd0, b_cpu_wait_n}, 16'h0000);
      step();
      check("t2_wait_c3",{15'd0, b_cpu_wait_n}, 16'h0000);
      step();
      check("t2_wait_hi",{15'd0, b_cpu_wait_n}, 16'h0001);
      check("t2_di",     {8'd0, b_cpu_di},      16'h00FF);
      strobes_idle();
      step();
      check("t2_idle",   {15'd0, b_busy},       16'h0000);

      // 3: I/O write, default waits, ack in the second request cycle.
      cpu_a = 16'h4281; cpu_do = 8'h25;
      cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
      step();
      check("t3_addr",   a_mem_addr,            16'h1081);
      check("t3_we",     {15'd0, a_mem_we},     16'h0001);
      check("t3_wdata",  {8'd0, a_mem_wdata},   16'h0025);
      check("t3_wait_c1",{15'd0, a_cpu_wait_n}, 16'h0000);
      step();
      check("t3_req_held",{15'd0, a_mem_req},   16'h0001);
      check("t3_wait_c2",{15'd0, a_cpu_wait_n}, 16'h0000);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("t3_wait_c3",{15'd0, a_cpu_wait_n}, 16'h0000);
      check("t3_req_off",{15'd0, a_mem_req},    16'h0000);
      step();
      check("t3_wait_hi",{15'd0, a_cpu_wait_n}, 16'h0001);
      check("t3_di",     {8'd0, a_cpu_di},      16'h00FF);
      strobes_idle();
      step();
      check("t3_idle",   {15'd0, a_busy},       16'h0000);

      // 4: refresh and interrupt acknowledge are ignored.
      cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0;
      step();
      step();
      check("t4_rfsh_req",  {15'd0, a_mem_req}, 16'h0000);
      check("t4_rfsh_busy", {15'd0, a_busy},    16'h0000);
      strobes_idle();
      cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0; cpu_rd_n = 1'b0;
      step();
      step();
      check("t4_inta_req",  {15'd0, a_mem_req}, 16'h0000);
      check("t4_inta_busy", {15'd0, a_busy},    16'h0000);
      strobes_idle();
      step();

      // 6a: abort in REQ, ack three cycles after the release.
      cpu_a = 16'h1234;
      cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
      step();
      check("t6_req",    {15'd0, a_mem_req},    16'h0001);
      strobes_idle();
      step();
      check("t6_wait_hi",{15'd0, a_cpu_wait_n}, 16'h0001);
      check("t6_req_kept",{15'd0, a_mem_req},   16'h0001);
      step();
      step();
      mem_rdata = 8'h55; mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("t6_req_off",{15'd0, a_mem_req},    16'h0000);
      check("t6_idle",   {15'd0, a_busy},       16'h0000);
      check("t6_di_kept",{8'd0, a_cpu_di},      16'h00FF);

      // 6b: ack in the same cycle as the release is also an abort.
      cpu_a = 16'h0042;
      cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
      step();
      strobes_idle();
      mem_rdata = 8'h77; mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("t6b_idle",  {15'd0, a_busy},       16'h0000);
      check("t6b_di",    {8'd0, a_cpu_di},      16'h00FF);

      // 6c: the next read is accepted normally.
      cpu_a = 16'h00A5; mem_rdata = 8'h5A;
      cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
      step();
      check("t6c_req",   {15'd0, a_mem_req},    16'h0001);
      check("t6c_addr",  a_mem_addr,            16'h00A5);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("t6c_di",    {8'd0, a_cpu_di},      16'h005A);
      check("t6c_wait",  {15'd0, a_cpu_wait_n}, 16'h0001);
      strobes_idle();
      step();

      // 5: reset while a request is outstanding and the ack is withheld.
      cpu_a = 16'h0F0F;
      cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
      step();
      check("t5_req",    {15'd0, a_mem_req},    16'h0001);
      reset = 1'b1;
      strobes_idle();
      step();
      check("t5_req_off",{15'd0, a_mem_req},    16'h0000);
      check("t5_wait",   {15'd0, a_cpu_wait_n}, 16'h0001);
      check("t5_di",     {8'd0, a_cpu_di},      16'h00FF);
      check("t5_addr",   a_mem_addr,            16'h0000);
      check("t5_busy",   {15'd0, a_busy},       16'h0000);
      reset = 1'b0;
      step();
      check("t5_stay_idle", {15'd0, a_busy},    16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
